// File: rtl/demosaic_pkg.sv
// Constants shared by the demosaic pipeline blocks: default pixel width,
// line-start border policies and a counter-width helper.
package demosaic_pkg;
    localparam int PIX_W_DEFAULT = 10;

    localparam int BORDER_NONE = 0;
    localparam int BORDER_ZERO = 1;
    localparam int BORDER_REPL = 2;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/window_shift_buffer_if.sv
// Column-in / window-out bundle between the line buffers, the sliding window
// and the interpolation kernels.
interface window_shift_buffer_if
    import demosaic_pkg::*;
#(
    parameter int DATA_W = PIX_W_DEFAULT,
    parameter int ROWS   = 3,
    parameter int COLS   = 3
);
    logic                          in_valid;
    logic                          in_sol;
    logic [ROWS*DATA_W-1:0]        in_col;
    logic [ROWS*COLS*DATA_W-1:0]   win_out;
    logic                          out_valid;
    logic                          out_sol;

    modport master (
        output in_valid, in_sol, in_col,
        input  win_out, out_valid, out_sol
    );

    modport slave (
        input  in_valid, in_sol, in_col,
        output win_out, out_valid, out_sol
    );
endinterface

// File: rtl/window_row_shift.sv
// One window row: COLS pixel registers, oldest in slice 0, newest in the top slice,
// with shift, zero-preset and replicate-preset loads of the older columns.
module window_row_shift #(
    parameter int DATA_W = 10,
    parameter int COLS   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic                     zero_load,
    input  logic                     repl_load,
    input  logic [DATA_W-1:0]        din,
    output logic [COLS*DATA_W-1:0]   row_out
);
    logic [COLS*DATA_W-1:0] row_reg;
    logic [COLS*DATA_W-1:0] row_next;

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            if (gi == COLS - 1) begin : g_newest
                assign row_next[gi*DATA_W +: DATA_W] = din;
            end else begin : g_older
                // Presets only matter on a line start; otherwise take the younger neighbour.
                assign row_next[gi*DATA_W +: DATA_W] =
                    zero_load ? {DATA_W{1'b0}} :
                    repl_load ? din :
                                row_reg[(gi+1)*DATA_W +: DATA_W];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_reg <= '0;
        end else if (shift_en) begin
            row_reg <= row_next;
        end
    end

    assign row_out = row_reg;
endmodule

// File: rtl/window_shift_buffer.sv
// Sliding ROWS x COLS pixel window fed one column per accepted beat; tracks the
// fill level since line start to flag complete windows.
module window_shift_buffer
    import demosaic_pkg::*;
#(
    parameter int DATA_W      = PIX_W_DEFAULT,
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int BORDER_MODE = BORDER_NONE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    window_shift_buffer_if.slave  bus
);
    localparam int               CNT_W    = cnt_w(COLS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             zero_load;
    logic             repl_load;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] fill_cnt_next;
    logic             out_valid_reg;
    logic             out_valid_next;
    logic             out_sol_reg;
    logic             out_sol_next;

    assign zero_load = bus.in_sol && (BORDER_MODE == BORDER_ZERO);
    assign repl_load = bus.in_sol && (BORDER_MODE == BORDER_REPL);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            window_row_shift #(
                .DATA_W (DATA_W),
                .COLS   (COLS)
            ) u_row (
                .clk       (clk),
                .rst_n     (rst_n),
                .shift_en  (bus.in_valid),
                .zero_load (zero_load),
                .repl_load (repl_load),
                .din       (bus.in_col[gi*DATA_W +: DATA_W]),
                .row_out   (bus.win_out[gi*COLS*DATA_W +: COLS*DATA_W])
            );
        end
    endgenerate

    // A zero count means no line start seen since reset, so it must not advance.
    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (bus.in_valid) begin
            if (bus.in_sol) begin
                fill_cnt_next = CNT_ONE;
            end else if (fill_cnt_reg != '0 && fill_cnt_reg != CNT_FULL) begin
                fill_cnt_next = fill_cnt_reg + CNT_ONE;
            end
        end
        out_valid_next = bus.in_valid && (fill_cnt_next != '0) &&
                         ((BORDER_MODE != BORDER_NONE) || (fill_cnt_next == CNT_FULL));
        out_sol_next   = bus.in_valid && bus.in_sol;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sol_reg   <= 1'b0;
        end else begin
            fill_cnt_reg  <= fill_cnt_next;
            out_valid_reg <= out_valid_next;
            out_sol_reg   <= out_sol_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_sol   = out_sol_reg;
endmodule

// File: tb/tb_window_shift_buffer.sv
// Directed bench: three 3x3 windows (NONE/ZERO/REPLICATE) share one column stream,
// plus a 2-row x 5-column NONE window for the mid-line reset case.
module tb_window_shift_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_v = 1'b0;
    logic        in_s = 1'b0;
    logic [29:0] col3 = '0;
    logic [19:0] col2 = '0;
    int          err_cnt = 0;
    int          chk_cnt = 0;

    always #5 clk = ~clk;

    window_shift_buffer_if #(.DATA_W(10), .ROWS(3), .COLS(3)) if_none ();
    window_shift_buffer_if #(.DATA_W(10), .ROWS(3), .COLS(3)) if_zero ();
    window_shift_buffer_if #(.DATA_W(10), .ROWS(3), .COLS(3)) if_repl ();
    window_shift_buffer_if #(.DATA_W(10), .ROWS(2), .COLS(5)) if_c5 ();

    assign if_none.in_valid = in_v;
    assign if_none.in_sol   = in_s;
    assign if_none.in_col   = col3;
    assign if_zero.in_valid = in_v;
    assign if_zero.in_sol   = in_s;
    assign if_zero.in_col   = col3;
    assign if_repl.in_valid = in_v;
    assign if_repl.in_sol   = in_s;
    assign if_repl.in_col   = col3;
    assign if_c5.in_valid   = in_v;
    assign if_c5.in_sol     = in_s;
    assign if_c5.in_col     = col2;

    window_shift_buffer #(.DATA_W(10), .ROWS(3), .COLS(3), .BORDER_MODE(0)) u_none (
        .clk(clk), .rst_n(rst_n), .bus(if_none.slave));
    window_shift_buffer #(.DATA_W(10), .ROWS(3), .COLS(3), .BORDER_MODE(1)) u_zero (
        .clk(clk), .rst_n(rst_n), .bus(if_zero.slave));
    window_shift_buffer #(.DATA_W(10), .ROWS(3), .COLS(3), .BORDER_MODE(2)) u_repl (
        .clk(clk), .rst_n(rst_n), .bus(if_repl.slave));
    window_shift_buffer #(.DATA_W(10), .ROWS(2), .COLS(5), .BORDER_MODE(0)) u_c5 (
        .clk(clk), .rst_n(rst_n), .bus(if_c5.slave));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Row of a 3-column window, arguments oldest to newest.
    function automatic logic [63:0] r3(input int a, input int b, input int c);
        return {34'd0, 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [63:0] r5(input int a, input int b, input int c,
                                       input int d, input int e);
        return {14'd0, 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [29:0] p3(input int k);
        return {3{10'(k)}};
    endfunction

    function automatic logic [19:0] c2(input int k);
        return {10'(k + 100), 10'(k)};
    endfunction

    task automatic step(input logic v, input logic s, input logic [29:0] c3v,
                        input logic [19:0] c2v);
        @(negedge clk);
        in_v = v;
        in_s = s;
        col3 = c3v;
        col2 = c2v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset dominates an accept of all-ones columns.
        rst_n = 1'b0;
        step(1'b1, 1'b0, p3(10'h3FF), 20'hFFFFF);
        step(1'b1, 1'b1, p3(10'h3FF), 20'hFFFFF);
        check_eq("rst_win_none", 64'(|if_none.win_out), 64'd0);
        check_eq("rst_win_zero", 64'(|if_zero.win_out), 64'd0);
        check_eq("rst_win_repl", 64'(|if_repl.win_out), 64'd0);
        check_eq("rst_win_c5",   64'(|if_c5.win_out),   64'd0);
        check_eq("rst_valid_zero", 64'(if_zero.out_valid), 64'd0);
        check_eq("rst_sol_none",   64'(if_none.out_sol),   64'd0);

        // Accepts before any line start shift but never flag valid.
        rst_n = 1'b1;
        step(1'b1, 1'b0, p3(5), 20'd0);
        step(1'b1, 1'b0, p3(5), 20'd0);
        check_eq("nosol_valid_none", 64'(if_none.out_valid), 64'd0);
        check_eq("nosol_valid_zero", 64'(if_zero.out_valid), 64'd0);
        check_eq("nosol_valid_repl", 64'(if_repl.out_valid), 64'd0);
        check_eq("nosol_row0_none",  64'(if_none.win_out[29:0]), r3(0, 5, 5));

        // Line start then columns 1..4.
        step(1'b1, 1'b1, p3(1), 20'd0);
        check_eq("sol1_valid_none", 64'(if_none.out_valid), 64'd0);
        check_eq("sol1_sol_none",   64'(if_none.out_sol),   64'd1);
        check_eq("sol1_row0_zero",  64'(if_zero.win_out[29:0]), r3(0, 0, 1));
        check_eq("sol1_valid_zero", 64'(if_zero.out_valid), 64'd1);
        check_eq("sol1_row0_repl",  64'(if_repl.win_out[29:0]), r3(1, 1, 1));
        check_eq("sol1_valid_repl", 64'(if_repl.out_valid), 64'd1);
        step(1'b1, 1'b0, p3(2), 20'd0);
        check_eq("c2_valid_none", 64'(if_none.out_valid), 64'd0);
        check_eq("c2_sol_zero",   64'(if_zero.out_sol),   64'd0);
        check_eq("c2_row0_zero",  64'(if_zero.win_out[29:0]), r3(0, 1, 2));
        check_eq("c2_row2_repl",  64'(if_repl.win_out[89:60]), r3(1, 1, 2));
        step(1'b1, 1'b0, p3(3), 20'd0);
        check_eq("c3_valid_none", 64'(if_none.out_valid), 64'd1);
        check_eq("c3_sol_none",   64'(if_none.out_sol),   64'd0);
        check_eq("c3_row0_none",  64'(if_none.win_out[29:0]), r3(1, 2, 3));
        step(1'b1, 1'b0, p3(4), 20'd0);
        check_eq("c4_valid_none", 64'(if_none.out_valid), 64'd1);
        check_eq("c4_row1_none",  64'(if_none.win_out[59:30]), r3(2, 3, 4));

        // Idle cycle: window holds, flags drop.
        step(1'b0, 1'b0, p3(9), 20'd0);
        check_eq("idle_valid_none", 64'(if_none.out_valid), 64'd0);
        check_eq("idle_valid_zero", 64'(if_zero.out_valid), 64'd0);
        check_eq("idle_row0_none",  64'(if_none.win_out[29:0]), r3(2, 3, 4));

        // Zero border on line start.
        step(1'b1, 1'b1, p3(10'h155), 20'd0);
        check_eq("zsol_row0_zero",  64'(if_zero.win_out[29:0]), r3(0, 0, 10'h155));
        check_eq("zsol_valid_zero", 64'(if_zero.out_valid), 64'd1);
        check_eq("zsol_sol_zero",   64'(if_zero.out_sol),   64'd1);
        check_eq("zsol_row0_none",  64'(if_none.win_out[29:0]), r3(3, 4, 10'h155));
        check_eq("zsol_valid_none", 64'(if_none.out_valid), 64'd0);

        // Replicate border with distinct rows 7/8/9.
        step(1'b1, 1'b1, {10'd9, 10'd8, 10'd7}, 20'd0);
        check_eq("rsol_row0_repl",  64'(if_repl.win_out[29:0]),  r3(7, 7, 7));
        check_eq("rsol_row1_repl",  64'(if_repl.win_out[59:30]), r3(8, 8, 8));
        check_eq("rsol_row2_repl",  64'(if_repl.win_out[89:60]), r3(9, 9, 9));
        check_eq("rsol_valid_repl", 64'(if_repl.out_valid), 64'd1);
        step(1'b1, 1'b0, p3(1), 20'd0);
        check_eq("rnext_row0_repl",  64'(if_repl.win_out[29:0]), r3(7, 7, 1));
        check_eq("rnext_valid_repl", 64'(if_repl.out_valid), 64'd1);
        check_eq("rnext_sol_repl",   64'(if_repl.out_sol),   64'd0);

        // Alternating gaps on a fresh line.
        step(1'b1, 1'b1, p3(10), 20'd0);
        step(1'b0, 1'b0, p3(0), 20'd0);
        check_eq("gap1_valid_none", 64'(if_none.out_valid), 64'd0);
        step(1'b1, 1'b0, p3(11), 20'd0);
        check_eq("gap_c11_valid_none", 64'(if_none.out_valid), 64'd0);
        step(1'b0, 1'b0, p3(0), 20'd0);
        step(1'b1, 1'b0, p3(12), 20'd0);
        check_eq("gap_c12_valid_none", 64'(if_none.out_valid), 64'd1);
        check_eq("gap_c12_row0_none",  64'(if_none.win_out[29:0]), r3(10, 11, 12));
        step(1'b0, 1'b1, p3(0), 20'd0);
        check_eq("gap3_valid_none", 64'(if_none.out_valid), 64'd0);
        check_eq("gap3_sol_none",   64'(if_none.out_sol),   64'd0);
        check_eq("gap3_row0_none",  64'(if_none.win_out[29:0]), r3(10, 11, 12));
        step(1'b1, 1'b0, p3(13), 20'd0);
        check_eq("gap_c13_row0_none", 64'(if_none.win_out[29:0]), r3(11, 12, 13));
        check_eq("gap_c13_valid_none", 64'(if_none.out_valid), 64'd1);

        // Back-to-back line starts, then a too-short line.
        step(1'b1, 1'b1, p3(20), 20'd0);
        step(1'b1, 1'b1, p3(21), 20'd0);
        check_eq("dsol_row0_repl",  64'(if_repl.win_out[29:0]), r3(21, 21, 21));
        check_eq("dsol_sol_repl",   64'(if_repl.out_sol), 64'd1);
        check_eq("dsol_row0_zero",  64'(if_zero.win_out[29:0]), r3(0, 0, 21));
        check_eq("dsol_valid_none", 64'(if_none.out_valid), 64'd0);
        step(1'b1, 1'b0, p3(22), 20'd0);
        check_eq("short_valid_none", 64'(if_none.out_valid), 64'd0);

        // 2x5 window: partial line, mid-line reset, accepts without SOL, new line.
        step(1'b1, 1'b1, p3(0), c2(1));
        step(1'b1, 1'b0, p3(0), c2(2));
        step(1'b1, 1'b0, p3(0), c2(3));
        check_eq("c5_part_valid", 64'(if_c5.out_valid), 64'd0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, p3(0), c2(4));
        check_eq("c5_rst_win",   64'(|if_c5.win_out), 64'd0);
        check_eq("c5_rst_valid", 64'(if_c5.out_valid), 64'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, p3(0), c2(5));
        check_eq("c5_nosol_valid", 64'(if_c5.out_valid), 64'd0);
        step(1'b1, 1'b1, p3(0), c2(11));
        check_eq("c5_sol_valid", 64'(if_c5.out_valid), 64'd0);
        check_eq("c5_sol_sol",   64'(if_c5.out_sol),   64'd1);
        for (int k = 12; k <= 14; k++) begin
            step(1'b1, 1'b0, p3(0), c2(k));
            check_eq($sformatf("c5_fill%0d_valid", k), 64'(if_c5.out_valid), 64'd0);
        end
        step(1'b1, 1'b0, p3(0), c2(15));
        check_eq("c5_full_valid", 64'(if_c5.out_valid), 64'd1);
        check_eq("c5_full_sol",   64'(if_c5.out_sol),   64'd0);
        check_eq("c5_full_row0",  64'(if_c5.win_out[49:0]),  r5(11, 12, 13, 14, 15));
        check_eq("c5_full_row1",  64'(if_c5.win_out[99:50]), r5(111, 112, 113, 114, 115));
        check_eq("c5_pix_r1c2",   64'(if_c5.win_out[70 +: 10]), 64'd113);
        step(1'b1, 1'b0, p3(0), c2(16));
        check_eq("c5_next_row0",  64'(if_c5.win_out[49:0]), r5(12, 13, 14, 15, 16));
        check_eq("c5_next_valid", 64'(if_c5.out_valid), 64'd1);

        step(1'b0, 1'b0, p3(0), 20'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
